// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package tt_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_MINTERMS = 16;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 5;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts 0..SETTLE-1 while enabled and flags the last cycle
// so the caller knows the function output has had time to settle.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign expire_o = (count_q == LAST);

  // Next count: clear wins, otherwise wrap to 0 after the last settle cycle
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      if (expire_o) begin
        count_d = 8'd0;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // Count register with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks {w,x,y,z} through all 16 minterms, samples the
// function output after SETTLE cycles per minterm and packs the results.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_MINTERMS-1:0] table_q, table_d;
  logic [CNT_W-1:0]        ones_q, ones_d;
  logic                    expire;
  logic                    timer_clear;
  logic                    timer_en;

  // The timer only runs in DRIVE; anywhere else it is held at zero so each
  // sweep starts from a fresh settle window.
  assign timer_clear = (state_q != DRIVE);
  assign timer_en    = (state_q == DRIVE);

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (timer_clear),
    .en_i    (timer_en),
    .expire_o(expire)
  );

  // Function inputs come straight from the index register
  assign {w, x, y, z} = idx_q;
  assign busy         = (state_q == DRIVE);
  assign done         = (state_q == DONE);
  assign table_out    = table_q;
  assign ones_count   = ones_q;

  // Next-state logic: accept start in IDLE, sample at each settle expiry,
  // leave after minterm 15, and pulse DONE for one cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
        end
      end
      DRIVE: begin
        if (expire) begin
          table_d[idx_q] = f_in;
          ones_d         = ones_q + {{(CNT_W-1){1'b0}}, f_in};
          if (idx_q == IDX_W'(NUM_MINTERMS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3)
// driven by a behavioural function model and checked against it.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startReq = 1'b0;
  logic        useThree = 1'b0;
  int          mode = 0;
  logic [15:0] rtbl = 16'h0000;

  logic        start1, f1, w1, x1, y1, z1, busy1, done1;
  logic [15:0] table1;
  logic [4:0]  ones1;
  logic        start3, f3, w3, x3, y3, z3, busy3, done3;
  logic [15:0] table3;
  logic [4:0]  ones3;

  logic        selBusy, selDone;
  logic [3:0]  selWxyz;
  logic [15:0] selTable;
  logic [4:0]  selOnes;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  // Function under test: 0 const0, 1 const1, 2 homework function,
  // 3 identity on w, otherwise a random truth table
  function automatic logic evalF(input int m, input logic [15:0] t,
                                 input logic [3:0] i);
    logic fw, fx, fy, fz;
    {fw, fx, fy, fz} = i;
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (fx | ~fw) & (fw | fy | ~fz) & (fx | fz | (~fx & ~fy));
      3:       return fw;
      default: return t[i];
    endcase
  endfunction

  assign start1 = startReq && !useThree;
  assign start3 = startReq && useThree;
  assign f1 = evalF(mode, rtbl, {w1, x1, y1, z1});
  assign f3 = evalF(mode, rtbl, {w3, x3, y3, z3});

  assign selBusy  = useThree ? busy3 : busy1;
  assign selDone  = useThree ? done3 : done1;
  assign selWxyz  = useThree ? {w3, x3, y3, z3} : {w1, x1, y1, z1};
  assign selTable = useThree ? table3 : table1;
  assign selOnes  = useThree ? ones3 : ones1;

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .w(w1), .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .table_out(table1), .ones_count(ones1)
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f3),
    .w(w3), .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
    .table_out(table3), .ones_count(ones3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] modelTable(input int m, input logic [15:0] t);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = evalF(m, t, 4'(i));
    return r;
  endfunction

  // One full sweep on the selected instance, tracking every cycle from
  // the accept edge until a few cycles after done
  task automatic applyStimulus(input int settle, input int m, input bit pulses,
                               input string tag);
    logic [15:0] expTable, gotTable;
    logic [4:0]  gotOnes;
    int last, busyCount, doneCount, doneAt;
    bit seqOk;
    useThree  = (settle == 3);
    mode      = m;
    expTable  = modelTable(m, rtbl);
    last      = 16 * settle;
    busyCount = 0;
    doneCount = 0;
    doneAt    = -1;
    seqOk     = 1'b1;
    gotTable  = 16'h0;
    gotOnes   = 5'h0;
    @(negedge clk);
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    for (int k = 0; k <= last + 3; k++) begin
      if (k > 0) @(negedge clk);
      startReq = pulses && (k == 5 || k == last);
      if (selBusy) busyCount++;
      if (selDone) begin
        doneCount++;
        doneAt   = k;
        gotTable = selTable;
        gotOnes  = selOnes;
      end
      if (selBusy !== (k < last)) seqOk = 1'b0;
      if (k < last && selWxyz !== 4'(k / settle)) seqOk = 1'b0;
    end
    startReq = 1'b0;
    checkOutput({tag, ".doneAt"},    doneAt,    last);
    checkOutput({tag, ".doneCount"}, doneCount, 1);
    checkOutput({tag, ".busyCycles"}, busyCount, last);
    checkOutput({tag, ".inputSeq"},  {31'd0, seqOk}, 32'd1);
    checkOutput({tag, ".table"},     gotTable,  expTable);
    checkOutput({tag, ".ones"},      gotOnes,   $countones(expTable));
  endtask

  initial begin
    logic [15:0] expB2b;
    int doneSeen;
    bit found;

    // Reset state
    #1;
    checkOutput("rst.table", table1, 16'h0000);
    checkOutput("rst.ones",  ones1,  5'd0);
    checkOutput("rst.busy",  busy1,  1'b0);
    checkOutput("rst.done",  done1,  1'b0);
    checkOutput("rst.wxyz",  {w1, x1, y1, z1}, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Constant and known functions
    applyStimulus(1, 1, 1'b0, "const1");
    checkOutput("const1.spec", table1, 16'hFFFF);
    applyStimulus(1, 0, 1'b0, "const0");
    applyStimulus(1, 2, 1'b0, "real");
    checkOutput("real.specTable", table1, 16'hF0D9);
    checkOutput("real.specOnes",  ones1,  5'd9);
    applyStimulus(3, 3, 1'b0, "ident3");
    checkOutput("ident3.spec", table3, 16'hFF00);
    checkOutput("ident3.hold", table3, 16'hFF00);

    // Start pulses during DRIVE and DONE are ignored
    rtbl = 16'($urandom);
    applyStimulus(1, 4, 1'b1, "pulse1");
    rtbl = 16'($urandom);
    applyStimulus(3, 4, 1'b1, "pulse3");

    // Random functions on both settle settings
    for (int r = 0; r < 3; r++) begin
      rtbl = 16'($urandom);
      applyStimulus(1, 4, 1'b0, "rand1");
      rtbl = 16'($urandom);
      applyStimulus(3, 4, 1'b0, "rand3");
    end

    // Back-to-back sweeps with start held high
    useThree = 1'b0;
    mode     = 4;
    rtbl     = 16'($urandom) | 16'h0001;
    expB2b   = modelTable(4, rtbl);
    @(negedge clk);
    startReq = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    checkOutput("b2b.done1",  done1,  1'b1);
    checkOutput("b2b.table1", table1, expB2b);
    @(negedge clk);
    checkOutput("b2b.idleBusy", busy1,  1'b0);
    checkOutput("b2b.hold",     table1, expB2b);
    @(negedge clk);
    checkOutput("b2b.reaccept", busy1,  1'b1);
    checkOutput("b2b.cleared",  table1, 16'h0000);
    doneSeen = 0;
    for (int k = 0; k < 30 && doneSeen == 0; k++) begin
      @(negedge clk);
      if (done1) doneSeen = k + 1;
    end
    startReq = 1'b0;
    checkOutput("b2b.secondDoneAt", doneSeen, 16);
    checkOutput("b2b.table2", table1, expB2b);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a sweep
    useThree = 1'b0;
    mode     = 1;
    @(negedge clk);
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if ({w1, x1, y1, z1} == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("mid.reachIdx7", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid.table", table1, 16'h0000);
    checkOutput("mid.ones",  ones1,  5'd0);
    checkOutput("mid.busy",  busy1,  1'b0);
    checkOutput("mid.wxyz",  {w1, x1, y1, z1}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done1 || busy1) doneSeen++;
    end
    checkOutput("mid.noDone", doneSeen, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
